// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
package issue_queue_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  typedef logic [REG_ADDR_W-1:0] RegAddrBus;
  typedef logic [REG_W-1:0]      RegBus;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b0;

  // Decode-relevant part of an entry; the issue checker only needs these bits.
  typedef struct packed {
    logic      we;
    RegAddrBus waddr;
    logic      re1;
    RegAddrBus raddr1;
    logic      re2;
    RegAddrBus raddr2;
    logic      is_mem;
    logic      is_br;
    logic      is_priv;
  } iq_ctrl_t;

  // Full queue entry: {pc, inst, we, waddr, re1, raddr1, re2, raddr2, is_mem, is_br, is_priv}
  typedef struct packed {
    RegBus    pc;
    RegBus    inst;
    iq_ctrl_t ctrl;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

  // Bit offsets of each field inside a packed entry (LSB first).
  localparam int OFF_IS_PRIV = 0;
  localparam int OFF_IS_BR   = 1;
  localparam int OFF_IS_MEM  = 2;
  localparam int OFF_RADDR2  = 3;
  localparam int OFF_RE2     = OFF_RADDR2 + REG_ADDR_W;
  localparam int OFF_RADDR1  = OFF_RE2 + 1;
  localparam int OFF_RE1     = OFF_RADDR1 + REG_ADDR_W;
  localparam int OFF_WADDR   = OFF_RE1 + 1;
  localparam int OFF_WE      = OFF_WADDR + REG_ADDR_W;
  localparam int OFF_INST    = OFF_WE + 1;
  localparam int OFF_PC      = OFF_INST + REG_W;

  // True when the entry reads register a; $0 never creates a dependency.
  function automatic logic reads_reg(input iq_ctrl_t c, input RegAddrBus a);
    return (a != '0) && ((c.re1 && (c.raddr1 == a)) || (c.re2 && (c.raddr2 == a)));
  endfunction

  // True when the entry consumes the destination of a load still in EX.
  function automatic logic ex_load_hazard(input iq_ctrl_t c,
                                          input logic ld1, input RegAddrBus wa1,
                                          input logic ld2, input RegAddrBus wa2);
    return (ld1 && reads_reg(c, wa1)) || (ld2 && reads_reg(c, wa2));
  endfunction

endpackage

// File: rtl/issue_queue_ctrl_if.sv
// Fetch / EX / issue signal bundle around the instruction queue.
interface issue_queue_ctrl_if;
  import issue_queue_ctrl_pkg::*;

  logic       flush;
  logic [3:0] stall;
  logic [1:0] push_valid;
  iq_entry_t  push_entry0;
  iq_entry_t  push_entry1;
  logic       queue_ready;
  logic       ex_is_load_i1;
  logic       ex_is_load_i2;
  RegAddrBus  ex_waddr_i1;
  RegAddrBus  ex_waddr_i2;
  logic       issue_valid;
  logic       issue_mode;
  iq_entry_t  issue_entry1;
  iq_entry_t  issue_entry2;
  logic       stallreq;

  // Pipeline side: fetch, EX stage and stall controller.
  modport master (
    output flush, stall, push_valid, push_entry0, push_entry1,
    output ex_is_load_i1, ex_is_load_i2, ex_waddr_i1, ex_waddr_i2,
    input  queue_ready, issue_valid, issue_mode, issue_entry1, issue_entry2, stallreq
  );

  // Queue side.
  modport slave (
    input  flush, stall, push_valid, push_entry0, push_entry1,
    input  ex_is_load_i1, ex_is_load_i2, ex_waddr_i1, ex_waddr_i2,
    output queue_ready, issue_valid, issue_mode, issue_entry1, issue_entry2, stallreq
  );

endinterface

// File: rtl/issue_queue_ctrl_dual_issue_check.sv
// Combinational issue decision for the two oldest queue entries.
module dual_issue_check
  import issue_queue_ctrl_pkg::*;
(
  input  iq_ctrl_t  head0,
  input  iq_ctrl_t  head1,
  input  logic      has_one,
  input  logic      has_two,
  input  logic      ex_is_load_i1,
  input  logic      ex_is_load_i2,
  input  RegAddrBus ex_waddr_i1,
  input  RegAddrBus ex_waddr_i2,
  output logic      issue_single,
  output logic      issue_dual,
  output logic      stallreq
);

  logic head0_ex_haz;
  logic head1_ex_haz;
  logic raw_pair;
  logic pair_ok;

  // Evaluate load-use stalls first, then every rule that can block pairing.
  always_comb begin
    head0_ex_haz = 1'b0;
    head1_ex_haz = 1'b0;
    raw_pair     = 1'b0;
    pair_ok      = 1'b0;
    issue_single = 1'b0;
    issue_dual   = 1'b0;
    stallreq     = 1'b0;

    head0_ex_haz = ex_load_hazard(head0, ex_is_load_i1, ex_waddr_i1, ex_is_load_i2, ex_waddr_i2);
    head1_ex_haz = ex_load_hazard(head1, ex_is_load_i1, ex_waddr_i1, ex_is_load_i2, ex_waddr_i2);
    raw_pair     = head0.we && reads_reg(head1, head0.waddr);

    stallreq     = has_one && head0_ex_haz;
    issue_single = has_one && !stallreq;

    pair_ok = has_two
              && !raw_pair
              && !(head0.is_mem && head1.is_mem)
              && !head1.is_br
              && !head0.is_priv
              && !head1.is_priv
              && !head1_ex_haz;

    issue_dual = issue_single && pair_ok;
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// 8-entry circular instruction queue feeding two ID/EX issue slots.
module issue_queue_ctrl
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  issue_queue_ctrl_if.slave iq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count;
  logic             has_one;
  logic             has_two;
  logic             push_ok;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic             single_ok;
  logic             dual_ok;
  logic             stall_req;
  iq_entry_t        head_e0;
  iq_entry_t        head_e1;
  logic             unused_stall;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign has_one = (count != '0);
  assign has_two = (count >= CNT_W'(2));
  assign head_e0 = mem[head];
  assign head_e1 = mem[head_p1];

  assign iq.queue_ready = (count <= CNT_W'(DEPTH - 2));
  assign push_ok        = iq.queue_ready && !iq.flush;
  assign unused_stall   = ^{iq.stall[3:2], iq.stall[0]};

  dual_issue_check u_check (
    .head0         (head_e0.ctrl),
    .head1         (head_e1.ctrl),
    .has_one       (has_one),
    .has_two       (has_two),
    .ex_is_load_i1 (iq.ex_is_load_i1),
    .ex_is_load_i2 (iq.ex_is_load_i2),
    .ex_waddr_i1   (iq.ex_waddr_i1),
    .ex_waddr_i2   (iq.ex_waddr_i2),
    .issue_single  (single_ok),
    .issue_dual    (dual_ok),
    .stallreq      (stall_req)
  );

  assign iq.issue_valid  = single_ok;
  assign iq.issue_mode   = dual_ok;
  assign iq.stallreq     = stall_req;
  assign iq.issue_entry1 = has_one ? head_e0 : '0;
  assign iq.issue_entry2 = dual_ok ? head_e1 : '0;

  // Accepted pushes (slot1 only counts alongside slot0) and pops this cycle.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (push_ok && iq.push_valid[0]) begin
      push_n = iq.push_valid[1] ? 2'd2 : 2'd1;
    end
    if ((iq.stall[1] == NoStop) && !iq.flush) begin
      pop_n = {1'b0, single_ok} + {1'b0, dual_ok};
    end
  end

  // Pointers and occupancy; flush empties the queue ahead of any push or pop.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (iq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Entry storage: slot0 lands at tail, slot1 at tail+1.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok && iq.push_valid[0]) begin
      mem[tail] <= iq.push_entry0;
      if (iq.push_valid[1]) begin
        mem[tail_p1] <= iq.push_entry1;
      end
    end
  end

endmodule
